data_memory_ctrl: RTL and testbench

//  Parametrised synchronous data memory for the CPU load/store path; replaces the

---
 rtl/data_memory_ctrl_if.sv | 28 ++
 rtl/data_memory_ctrl.sv | 130 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Load/store port between the datapath and data_memory_ctrl; par_inject exists only
// when DMEM_PARITY_EN is defined.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              MW;
  logic [31:0]       Bus_A;
  logic [31:0]       Bus_B;
  logic [DATA_W/8-1:0] be;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] data_out;
`ifdef DMEM_PARITY_EN
  logic              par_inject;

  modport master (output req, MW, Bus_A, Bus_B, be, par_inject,
                  input  ready, done, err, data_out);
  modport slave  (input  req, MW, Bus_A, Bus_B, be, par_inject,
                  output ready, done, err, data_out);
`else
  modport master (output req, MW, Bus_A, Bus_B, be,
                  input  ready, done, err, data_out);
  modport slave  (input  req, MW, Bus_A, Bus_B, be,
                  output ready, done, err, data_out);
`endif
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port data memory, req/ready handshake, done 1+WAIT_STATES cycles after accept;
// req is ignored while busy. Optional per-lane parity under DMEM_PARITY_EN.
module data_memory_ctrl #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_ctrl_if.slave  bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [3:0]          wcnt;
  logic                lat_mw;
  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   lat_dat;
  logic [LANES-1:0]    lat_be;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   dout_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   rd_word;
  logic                par_bad;
  logic                unused_bus_b;

  assign in_range     = lat_addr < 32'(DEPTH);
  assign idx          = lat_addr[ADDR_W-1:0];
  assign rd_word      = mem[idx];
  assign unused_bus_b = ^(bus.Bus_B >> DATA_W);

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;

`ifdef DMEM_PARITY_EN
  logic             lat_pinj;
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] par_rd;

  assign par_rd = par_mem[idx];

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < LANES; i++)
      par_bad = par_bad | (^{rd_word[i*8 +: 8], par_rd[i]});
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      lat_pinj <= 1'b0;
    else if (state == S_IDLE && bus.req)
      lat_pinj <= bus.par_inject;
`else
  assign par_bad = 1'b0;
`endif

  // Array is not reset; writes commit only on the RESP edge so a reset aborts them.
  always_ff @(posedge clk) begin
    if (state == S_RESP && lat_mw && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (lat_be[i]) begin
          mem[idx][i*8 +: 8] <= lat_dat[i*8 +: 8];
`ifdef DMEM_PARITY_EN
          par_mem[idx][i] <= (^lat_dat[i*8 +: 8]) ^ lat_pinj;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wcnt     <= 4'd0;
      lat_mw   <= 1'b0;
      lat_addr <= 32'd0;
      lat_dat  <= '0;
      lat_be   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            lat_mw   <= bus.MW;
            lat_addr <= bus.Bus_A;
            lat_dat  <= bus.Bus_B[DATA_W-1:0];
            lat_be   <= bus.be;
            ready_q  <= 1'b0;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              wcnt  <= 4'(WAIT_STATES - 1);
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0)
            state <= S_RESP;
          else
            wcnt <= wcnt - 4'd1;
        end
        S_RESP: begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state   <= S_IDLE;
          err_q   <= !in_range || (!lat_mw && par_bad);
          if (!lat_mw)
            dout_q <= in_range ? rd_word : '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: WAIT_STATES=1 and WAIT_STATES=0 instances, table vectors,
// hand sequences for reset/busy/parity, and random traffic against an array model.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit          sel;
  logic        req;
  logic        mw;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [1:0]  be;
  logic        pinj;

  data_memory_ctrl_if #(.DATA_W(16)) b1 ();
  data_memory_ctrl_if #(.DATA_W(16)) b0 ();

  data_memory_ctrl #(.DATA_W(16), .DEPTH(32), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  data_memory_ctrl #(.DATA_W(16), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));

  assign b1.req = req & sel;
  assign b0.req = req & ~sel;
  assign b1.MW = mw;     assign b0.MW = mw;
  assign b1.Bus_A = addr; assign b0.Bus_A = addr;
  assign b1.Bus_B = wdat; assign b0.Bus_B = wdat;
  assign b1.be = be;     assign b0.be = be;
`ifdef DMEM_PARITY_EN
  assign b1.par_inject = pinj;
  assign b0.par_inject = pinj;
`endif

  logic        rdy_o, done_o, err_o;
  logic [15:0] dout_o;
  assign rdy_o  = sel ? b1.ready    : b0.ready;
  assign done_o = sel ? b1.done     : b0.done;
  assign err_o  = sel ? b1.err      : b0.err;
  assign dout_o = sel ? b1.data_out : b0.data_out;

  int total = 0;
  int bad   = 0;

  // Reference: plain word arrays per instance plus the last value seen on data_out.
  logic [15:0] m [2][32];
  logic [15:0] last [2];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] xd;
    bit          xe;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit w, input logic [31:0] a, input logic [15:0] d,
                            input logic [1:0] b, output logic [15:0] xd, output bit xe);
    int s = sel ? 1 : 0;
    xe = (a >= 32);
    if (w) begin
      if (!xe) begin
        if (b[0]) m[s][a[4:0]][7:0]  = d[7:0];
        if (b[1]) m[s][a[4:0]][15:8] = d[15:8];
      end
      xd = last[s];
    end else begin
      xd = xe ? 16'h0000 : m[s][a[4:0]];
      last[s] = xd;
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] b, input bit pi, input bit hold,
                      output logic [15:0] dout, output logic e);
    int lat = 0;
    for (int n = 0; n < 20 && !rdy_o; n++) begin
      @(posedge clk); #1;
    end
    check("ready_before_req", rdy_o, 1'b1);
    mw = w; addr = a; wdat = {16'hDEAD, d}; be = b; pinj = pi; req = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      mw = 1'b1; addr = 32'd9; wdat = 32'h0000_9999; be = 2'b11;
    end else begin
      req = 1'b0;
    end
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_o && lat < 40);
    req = 1'b0;
    check("latency", 32'(lat), sel ? 32'd2 : 32'd1);
    check("ready_at_done", rdy_o, 1'b1);
    dout = dout_o;
    e = err_o;
    @(posedge clk); #1;
    check("single_done", done_o, 1'b0);
  endtask

  task automatic model_xfer(input bit w, input logic [31:0] a, input logic [15:0] d,
                            input logic [1:0] b, input bit hold);
    logic [15:0] xd, dout;
    bit xe;
    logic e;
    model_step(w, a, d, b, xd, xe);
    xfer(w, a, d, b, 1'b0, hold, dout, e);
    check("data_out", dout, xd);
    check("err", e, xe);
  endtask

  initial begin
    logic [15:0] dout, xd;
    logic e;
    bit xe;
    logic [31:0] ra;

    tbl[0]  = '{1'b1, 32'd4,        16'h0002, 2'b11, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 32'd4,        16'h0000, 2'b00, 16'h0002, 1'b0};
    tbl[2]  = '{1'b1, 32'd5,        16'h1234, 2'b11, 16'h0002, 1'b0};
    tbl[3]  = '{1'b1, 32'd5,        16'hABCD, 2'b01, 16'h0002, 1'b0};
    tbl[4]  = '{1'b0, 32'd5,        16'h0000, 2'b00, 16'h12CD, 1'b0};
    tbl[5]  = '{1'b0, 32'd32,       16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[6]  = '{1'b1, 32'h24,       16'hBEEF, 2'b11, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 32'd0,        16'h0000, 2'b00, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 32'd4,        16'h0000, 2'b00, 16'h0002, 1'b0};
    tbl[9]  = '{1'b1, 32'd6,        16'h7777, 2'b00, 16'h0002, 1'b0};
    tbl[10] = '{1'b0, 32'd6,        16'h0000, 2'b00, 16'h0000, 1'b0};
    tbl[11] = '{1'b0, 32'hFFFF_FFE4, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 32'd31,       16'hFFFF, 2'b10, 16'h0000, 1'b0};
    tbl[13] = '{1'b0, 32'd31,       16'h0000, 2'b00, 16'hFF00, 1'b0};

    for (int s = 0; s < 2; s++) begin
      last[s] = 16'h0000;
      for (int i = 0; i < 32; i++) m[s][i] = 16'h0000;
    end
    sel = 1'b1; req = 1'b0; mw = 1'b0; addr = '0; wdat = '0; be = '0; pinj = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", b1.ready, 1'b1);
    check("rst_done", b1.done, 1'b0);
    check("rst_err", b1.err, 1'b0);
    check("rst_data_out", b1.data_out, 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    // Bring both arrays to a known zero image through the port.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 32; i++) model_xfer(1'b1, 32'(i), 16'h0000, 2'b11, 1'b0);
    end
    sel = 1'b1;

    // Reset in the middle of a write's wait state: write must not land.
    model_xfer(1'b1, 32'd7, 16'h0055, 2'b11, 1'b0);
    model_xfer(1'b0, 32'd7, 16'h0000, 2'b00, 1'b0);
    mw = 1'b1; addr = 32'd4; wdat = 32'h0000_00AA; be = 2'b11; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", b1.ready, 1'b1);
    check("midrst_done", b1.done, 1'b0);
    check("midrst_data_out", b1.data_out, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    last[0] = 16'h0000;
    last[1] = 16'h0000;
    #1;
    model_xfer(1'b0, 32'd4, 16'h0000, 2'b00, 1'b0);

    for (int i = 0; i < 14; i++) begin
      model_step(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, xd, xe);
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, 1'b0, 1'b0, dout, e);
      check($sformatf("vec%0d_data", i), dout, tbl[i].xd);
      check($sformatf("vec%0d_err", i), e, tbl[i].xe);
    end

    // req held high while busy, pointing at addr 9: must be dropped, not queued.
    model_xfer(1'b1, 32'd3, 16'h1111, 2'b11, 1'b1);
    model_xfer(1'b0, 32'd9, 16'h0000, 2'b00, 1'b0);
    model_xfer(1'b0, 32'd3, 16'h0000, 2'b00, 1'b0);

    sel = 1'b0;
    model_xfer(1'b1, 32'd2, 16'h4242, 2'b11, 1'b1);
    model_xfer(1'b0, 32'd9, 16'h0000, 2'b00, 1'b0);
    model_xfer(1'b0, 32'd2, 16'h0000, 2'b00, 1'b0);
    sel = 1'b1;

`ifdef DMEM_PARITY_EN
    model_step(1'b1, 32'd5, 16'h0007, 2'b11, xd, xe);
    xfer(1'b1, 32'd5, 16'h0007, 2'b11, 1'b1, 1'b0, dout, e);
    model_step(1'b0, 32'd5, 16'h0000, 2'b00, xd, xe);
    xfer(1'b0, 32'd5, 16'h0000, 2'b00, 1'b0, 1'b0, dout, e);
    check("par_bad_data", dout, 16'h0007);
    check("par_bad_err", e, 1'b1);
    model_xfer(1'b1, 32'd5, 16'h0007, 2'b11, 1'b0);
    model_xfer(1'b0, 32'd5, 16'h0000, 2'b00, 1'b0);
`endif

    for (int k = 0; k < 260; k++) begin
      sel = (k % 4 != 3);
      ra = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
      model_xfer(1'($urandom_range(0, 1)), ra, 16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
